riscv_seq_divider: RTL and testbench

RISCV_SEQ_DIVIDER -- requirements
Module: riscv_seq_divider

---
 rtl/riscv_seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_riscv_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_divider.sv
// Sequential RISC-V M-extension divider (DIV/DIVU/REM/REMU).
// Restoring radix-2 division: one quotient bit per cycle, MSB first.
// Divide-by-zero and signed overflow complete without iterating.
// The result and tag are registered and read as zero whenever no response is pending.
module riscv_seq_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cancel,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_dividend,
  input  logic [DATA_WIDTH-1:0] req_divisor,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } state_e;

  state_e                state_q, state_d;
  logic                  rem_sel_q, rem_sel_d;   // 1: remainder result, 0: quotient
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;         // |divisor|
  logic [DATA_WIDTH-1:0] quo_q, quo_d;           // |dividend| shifting out, quotient shifting in
  logic [DATA_WIDTH-1:0] rem_q, rem_d;           // partial remainder
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

  // Two's complement negation.
  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
    return (~x) + DATA_WIDTH'(1);
  endfunction

  // Magnitude of an operand, honouring signedness.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x,
                                                      input logic               sgn);
    return (sgn && x[DATA_WIDTH-1]) ? negate(x) : x;
  endfunction

  logic                  accept_s;
  logic                  is_signed_s;
  logic                  div_zero_s;
  logic                  ovf_s;
  logic [DATA_WIDTH:0]   trial_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic                  ge_s;
  logic [DATA_WIDTH-1:0] rem_next_s;
  logic [DATA_WIDTH-1:0] quo_next_s;

  assign accept_s    = req_valid && (state_q == IDLE) && !cancel;
  assign is_signed_s = ~req_op[0];
  assign div_zero_s  = (req_divisor == {DATA_WIDTH{1'b0}});
  assign ovf_s       = is_signed_s
                       && (req_dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                       && (req_divisor == {DATA_WIDTH{1'b1}});

  // One restoring step on the (DATA_WIDTH+1)-bit subtractor. Since rem_q < divisor,
  // trial >= divisor exactly when the trial MSB is set or the subtraction did not borrow.
  assign trial_s    = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff_s     = trial_s - {1'b0, dvsr_q};
  assign ge_s       = trial_s[DATA_WIDTH] | ~diff_s[DATA_WIDTH];
  assign rem_next_s = ge_s ? diff_s[DATA_WIDTH-1:0] : trial_s[DATA_WIDTH-1:0];
  assign quo_next_s = {quo_q[DATA_WIDTH-2:0], ge_s};

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    tag_d     = tag_q;
    dvsr_d    = dvsr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    rsp_tag_d = rsp_tag_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          rem_sel_d = req_op[1];
          q_neg_d   = is_signed_s && (req_dividend[DATA_WIDTH-1] ^ req_divisor[DATA_WIDTH-1]);
          r_neg_d   = is_signed_s && req_dividend[DATA_WIDTH-1];
          tag_d     = req_tag;
          dvsr_d    = magnitude(req_divisor, is_signed_s);
          quo_d     = magnitude(req_dividend, is_signed_s);
          rem_d     = {DATA_WIDTH{1'b0}};
          cnt_d     = {CW{1'b0}};
          if (div_zero_s) begin
            state_d   = DONE;
            res_d     = req_op[1] ? req_dividend : {DATA_WIDTH{1'b1}};
            rsp_tag_d = req_tag;
          end else if (ovf_s) begin
            state_d   = DONE;
            res_d     = req_op[1] ? {DATA_WIDTH{1'b0}} : req_dividend;
            rsp_tag_d = req_tag;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d   = DONE;
            res_d     = rem_sel_q ? (r_neg_q ? negate(rem_next_s) : rem_next_s)
                                  : (q_neg_q ? negate(quo_next_s) : quo_next_s);
            rsp_tag_d = tag_q;
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        if (cancel || rsp_ready) begin
          state_d   = IDLE;
          res_d     = {DATA_WIDTH{1'b0}};
          rsp_tag_d = {TAG_WIDTH{1'b0}};
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        res_d     = {DATA_WIDTH{1'b0}};
        rsp_tag_d = {TAG_WIDTH{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      tag_q     <= {TAG_WIDTH{1'b0}};
      dvsr_q    <= {DATA_WIDTH{1'b0}};
      quo_q     <= {DATA_WIDTH{1'b0}};
      rem_q     <= {DATA_WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      res_q     <= {DATA_WIDTH{1'b0}};
      rsp_tag_q <= {TAG_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      tag_q     <= tag_d;
      dvsr_q    <= dvsr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = res_q;
  assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Directed + small randomized bench for riscv_seq_divider with a scoreboard queue.
module tb_riscv_seq_divider;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n, cancel, req_valid, rsp_ready;
  logic          req_ready, rsp_valid, busy;
  logic [1:0]    req_op;
  logic [W-1:0]  req_dividend, req_divisor, rsp_data;
  logic [TW-1:0] req_tag, rsp_tag;

  always #5 clk = ~clk;

  riscv_seq_divider #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cancel(cancel),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference model of the RISC-V division semantics.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb_;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    if (!op[0]) begin
      sa  = $signed(a);
      sb_ = $signed(b);
      return op[1] ? 32'(sa % sb_) : 32'(sa / sb_);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Present a request for one accepted cycle, then scramble inputs.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tg, input bit push);
    int   guard = 0;
    exp_t e;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_dividend = a; req_divisor = b; req_tag = tg;
    if (push) begin
      e.data = model(op, a, b);
      e.tag  = tg;
      e.lat  = is_special(op, a, b) ? 1 : W + 1;
      sb.push_back(e);
    end
    step();
    req_valid = 1'b0;
    req_op = 2'($urandom); req_dividend = $urandom; req_divisor = $urandom; req_tag = TW'($urandom);
  endtask

  // Wait (bounded) for a response; compare it with the scoreboard head.
  task automatic wait_rsp();
    int   lat = 1;
    exp_t e;
    while (!rsp_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.data = '0; e.tag = '0; e.lat = 0; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
    chk("req_ready_in_done", 32'(req_ready), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
  endtask

  // Complete the handshake while offering a request that must be ignored.
  task automatic handshake();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = OP_DIVU; req_dividend = 32'd50; req_divisor = 32'd5;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hs_rsp_data_zero", rsp_data, 32'd0);
    chk("hs_rsp_tag_zero", 32'(rsp_tag), 32'd0);
    chk("hs_no_accept", 32'(busy), 32'd0);
  endtask

  task automatic no_rsp_for(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      step();
      if (rsp_valid) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  logic [W-1:0]  hold_d;
  logic [TW-1:0] hold_t;

  initial begin
    rst_n = 1'b0; cancel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'b00; req_dividend = '0; req_divisor = '0; req_tag = '0;
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic unsigned and signed results.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);         wait_rsp(); handshake();
    issue(OP_REMU, 32'd100, 32'd7, 5'd3, 1'b1);         wait_rsp(); handshake();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);    wait_rsp(); handshake();
    chk("div_neg_value", 32'hFFFF_FFFD, model(OP_DIV, 32'hFFFF_FFF9, 32'd2));
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);    wait_rsp(); handshake();

    // Divide by zero and signed overflow bypass the iteration.
    issue(OP_DIVU, 32'd5, 32'd0, 5'd6, 1'b1);                    wait_rsp(); handshake();
    issue(OP_REM, 32'h8000_0000, 32'd0, 5'd7, 1'b1);             wait_rsp(); handshake();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);     wait_rsp(); handshake();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);     wait_rsp(); handshake();
    // Same operands unsigned iterate normally.
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1);   wait_rsp(); handshake();

    // Cancel on the 10th BUSY cycle.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd11, 1'b0);
    repeat (9) step();
    chk("busy_before_cancel", 32'(busy), 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_req_ready", 32'(req_ready), 32'd1);
    chk("cancel_busy", 32'(busy), 32'd0);
    no_rsp_for("cancel_no_rsp", 40);
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd12, 1'b1);       wait_rsp(); handshake();

    // Cancel blocks acceptance in IDLE.
    cancel = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_divisor = 32'd1;
    step();
    cancel = 1'b0; req_valid = 1'b0;
    chk("cancel_blocks_accept", 32'(busy), 32'd0);

    // Backpressure: response held stable for 5 cycles.
    issue(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd13, 1'b1);   wait_rsp();
    hold_d = rsp_data;
    hold_t = rsp_tag;
    repeat (5) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, hold_d);
      chk("hold_tag", 32'(rsp_tag), 32'(hold_t));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    handshake();

    // Cancel wins over rsp_ready in DONE.
    issue(OP_DIVU, 32'd9, 32'd0, 5'd14, 1'b0);
    chk("done_before_cancel", 32'(rsp_valid), 32'd1);
    cancel = 1'b1; rsp_ready = 1'b1;
    step();
    cancel = 1'b0; rsp_ready = 1'b0;
    chk("cancel_done_valid", 32'(rsp_valid), 32'd0);
    chk("cancel_done_ready", 32'(req_ready), 32'd1);

    // Reset mid-operation discards the operation.
    issue(OP_DIV, 32'd12345, 32'd6, 5'd15, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", rsp_data, 32'd0);
    no_rsp_for("midrst_no_rsp", 40);

    // Randomized operands against the model.
    for (int i = 0; i < 6; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd1;
      issue(op, a, b, TW'(i + 16), 1'b1);
      wait_rsp();
      handshake();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
